match_word_serializer: RTL

- Sits directly upstream of the match output stream and consumes the index produced by the fixed-priority one-hot word arbiter.
- Captures one word of per-engine match flags and pattern IDs from the parallel Aho-Corasick engines.
- Emits the matches one per cycle on a valid/ready stream, lowest engine index first, then releases the word.
- Provides per-word backpressure to the engine array and a saturating emitted-match counter.

---
 rtl/match_word_serializer_pkg.sv | 18 +
 rtl/match_word_serializer_arb.sv | 22 ++
 rtl/match_word_serializer.sv | 91 +++++++++
 3 files changed

// File: rtl/match_word_serializer_pkg.sv
// Shared constants and record type for the match word serializer.
// The record type describes one emitted match beat at default widths.
package match_word_serializer_pkg;

    localparam int REQ_NUM_DEF   = 8;
    localparam int ID_W_DEF      = 16;
    localparam int POS_W_DEF     = 32;
    localparam int REQ_NUM_W_DEF = (REQ_NUM_DEF == 1) ? 1 : $clog2(REQ_NUM_DEF);
    localparam int MATCH_CNT_W   = 32;

    typedef struct packed {
        logic [REQ_NUM_W_DEF-1:0] engine;
        logic [ID_W_DEF-1:0]      id;
        logic [POS_W_DEF-1:0]     pos;
        logic                     last;
    } match_rec_t;

endpackage

// File: rtl/match_word_serializer_arb.sv
// Fixed-priority arbiter over a match word: lowest set lane wins.
// Gives both the one-hot grant and its binary index.
module one_hot_word_arb #(
    parameter int REQ_NUM   = 8,
    parameter int REQ_NUM_W = (REQ_NUM == 1) ? 1 : $clog2(REQ_NUM)
) (
    input  logic [REQ_NUM-1:0]   req_i,
    output logic [REQ_NUM-1:0]   gnt_o,
    output logic [REQ_NUM_W-1:0] idx_o
);

    assign gnt_o = req_i & (~req_i + REQ_NUM'(1));

    // Scan from the top so the lowest set lane is written last.
    always_comb begin
        idx_o = '0;
        for (int i = REQ_NUM - 1; i >= 0; i--) begin
            if (req_i[i]) idx_o = REQ_NUM_W'(i);
        end
    end

endmodule

// File: rtl/match_word_serializer.sv
// Captures one word of per-engine matches and streams them out one per
// cycle, lowest engine first, refilling in the cycle of the last beat.
module match_word_serializer
    import match_word_serializer_pkg::*;
#(
    parameter int REQ_NUM   = REQ_NUM_DEF,
    parameter int ID_W      = ID_W_DEF,
    parameter int POS_W     = POS_W_DEF,
    parameter int REQ_NUM_W = (REQ_NUM == 1) ? 1 : $clog2(REQ_NUM)
) (
    input  logic                    clk_i,
    input  logic                    rst_n_i,
    input  logic                    word_valid_i,
    output logic                    word_ready_o,
    input  logic [REQ_NUM-1:0]      match_valid_i,
    input  logic [REQ_NUM*ID_W-1:0] match_id_i,
    input  logic [POS_W-1:0]        word_pos_i,
    output logic                    out_valid_o,
    input  logic                    out_ready_i,
    output logic [REQ_NUM_W-1:0]    out_engine_o,
    output logic [ID_W-1:0]         out_id_o,
    output logic [POS_W-1:0]        out_pos_o,
    output logic                    out_last_o,
    output logic [MATCH_CNT_W-1:0]  match_cnt_o
);

    localparam logic [REQ_NUM-1:0] ONE = REQ_NUM'(1);

    logic [REQ_NUM-1:0]     pending_q;
    logic [REQ_NUM-1:0]     pending_d;
    logic [REQ_NUM-1:0]     gnt;
    logic [ID_W-1:0]        ids_q [REQ_NUM];
    logic [POS_W-1:0]       pos_q;
    logic [MATCH_CNT_W-1:0] cnt_q;
    logic [MATCH_CNT_W-1:0] cnt_d;
    logic                   hs;
    logic                   accept;

    one_hot_word_arb #(
        .REQ_NUM   (REQ_NUM),
        .REQ_NUM_W (REQ_NUM_W)
    ) u_arb (
        .req_i (pending_q),
        .gnt_o (gnt),
        .idx_o (out_engine_o)
    );

    assign out_valid_o  = |pending_q;
    assign out_last_o   = out_valid_o && ((pending_q & (pending_q - ONE)) == '0);
    assign out_id_o     = ids_q[out_engine_o];
    assign out_pos_o    = pos_q;
    assign match_cnt_o  = cnt_q;

    assign hs           = out_valid_o && out_ready_i;
    assign word_ready_o = (pending_q == '0) || (hs && out_last_o);
    assign accept       = word_valid_i && word_ready_o;

    // A new word overwrites the mask even when the last beat clears a bit.
    always_comb begin
        pending_d = pending_q;
        if (accept) begin
            pending_d = match_valid_i;
        end else if (hs) begin
            pending_d = pending_q & ~gnt;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (hs && (cnt_q != '1)) cnt_d = cnt_q + MATCH_CNT_W'(1);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q <= '0;
            pos_q     <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < REQ_NUM; i++) ids_q[i] <= '0;
        end else begin
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
            if (accept) begin
                pos_q <= word_pos_i;
                for (int i = 0; i < REQ_NUM; i++) begin
                    ids_q[i] <= match_id_i[i*ID_W +: ID_W];
                end
            end
        end
    end

endmodule
